uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among 4 requesters.
- The transmitter is one bit per clock, with an active-low start, per-frame parity/data-width/stop-bit controls, and no busy output.
- This block stores a per-requester frame configuration, arbitrates, presents byte and config to the transmitter, and fires its start strobe.
- It times each frame by cycle count and returns a done pulse to the winner.

Parameters:
- NREQ, 4, number of requesters (fixed at 4; the index is 2 bits).
- GAP, 1, idle cycles inserted between consecutive frames (0..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  4  request, one bit per requester; level, held until done.
- din_all  input  32  byte of requester i on din_all[8i+7:8i].
- cfg_we  input  1  config write strobe.
- cfg_idx  input  2  requester index for the config write.
- cfg_data  input  4  {par[1:0], snum, dnum}.
- tx_start_n  output  1  transmitter start strobe, active low.
- tx_din  output  8  byte to transmitter.
- tx_par  output  2  parity select: 00 odd, 11 even, 01/10 none.
- tx_snum  output  1  1 = one stop bit, 0 = two stop bits.
- tx_dnum  output  1  1 = 7 data bits, 0 = 8 data bits.
- grant  output  4  one-hot owner of the current frame; 0 when idle.
- done  output  4  one-cycle pulse to the owner at frame end.
- busy  output  1  high from ARB through the end of GAP.

Behaviour:
- Reset (rst=0, async) forces:
  - tx_start_n=1, tx_din=0, tx_par=01, tx_snum=1, tx_dnum=0.
  - grant=0, done=0, busy=0.
  - rr pointer=0; all four cfg registers=4'b0110; FSM=IDLE.
- Reset mid-frame aborts the frame with no done pulse.
- Config write: on cfg_we=1, cfg_reg[cfg_idx]<=cfg_data at the clock edge.
  - Accepted in any state.
  - Outputs latched for a frame in progress are unaffected.
  - If the write coincides with ARB latching that same index, ARB latches the old value.
- FSM states: IDLE, ARB, START, SEND, GAP.
- IDLE: if req!=0, go to ARB; otherwise stay, with tx_start_n=1.
- ARB (1 cycle):
  - Winner = first set req bit scanning ptr, ptr+1, ... modulo 4.
  - Latch tx_din, tx_par/tx_snum/tx_dnum (from cfg_reg[winner]) and grant.
  - Set busy=1 and ptr<=winner+1 (mod 4).
  - If req has dropped to 0 this cycle, return to IDLE with grant=0.
- START (1 cycle): tx_start_n=0 for exactly this cycle. Load cnt<=FLEN-1, where FLEN=11 if tx_snum=1 and 12 if tx_snum=0.
- SEND: tx_start_n=1; cnt decrements each cycle. When cnt==1, the next state is GAP and done[winner] pulses in the first GAP cycle.
  - done therefore rises exactly FLEN cycles after the tx_start_n low cycle.
- GAP:
  - grant clears with the done pulse.
  - Wait GAP cycles; if GAP=0, leave after the done cycle.
  - Then go to ARB if req!=0, else to IDLE with busy=0.
- tx_din/tx_par/tx_snum/tx_dnum hold their values from ARB until the next ARB.
- Dropping req mid-frame does not abort. The frame completes and done still pulses.
- A requester must deassert req in the done cycle, or it re-enters arbitration. Round-robin places it last.
- A request arriving during SEND/GAP waits; there is no preemption.
- Counter is 4 bits. FLEN is taken from the latched tx_snum, not a live cfg register.

Test Plan:
- Single requester: cfg 2 = 4'b0110, req=0100, din byte2=0xA5.
  - Required: ARB next cycle, then tx_start_n low 1 cycle, tx_din=A5, tx_par=01, grant=0100.
  - done=0100 exactly 11 cycles after the start-low cycle.
- Round-robin: req=1111 held, after reset.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001.
  - Start strobes spaced FLEN+GAP+2 cycles apart.
- Stop-bit length: cfg 0 = 4'b1100 (even, 2 stop, 8 bits).
  - Required: done 12 cycles after start; tx_par=11, tx_snum=0.
- Config write mid-frame: write cfg 1 = 4'b0001 during requester 1's SEND.
  - Required: current frame keeps its old tx_dnum=0; the next frame from requester 1 shows tx_dnum=1.
- Reset mid-SEND: rst low for 1 cycle at cnt=5.
  - Required: all outputs at reset values immediately, no done pulse, ptr=0.
- Request dropped: requester 3 drops req after START.
  - Required: frame completes, done=1000, FSM returns to IDLE, busy=0 after GAP.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Bus bundle between the UART transmit scheduler and its surroundings.
//   master : requesters + config writer + transmitter observer (drives req/din/cfg)
//   slave  : the scheduler (drives transmitter controls, grant, done, busy)
// Signals:
//   req[NREQ]      level request per requester, held until its done pulse
//   din_all[8*NREQ] byte of requester i on din_all[8i+7:8i]
//   cfg_we/idx/data per-requester frame config write {par[1:0], snum, dnum}
//   tx_start_n     active-low start strobe to the transmitter
//   tx_din/tx_par/tx_snum/tx_dnum  frame byte and format to the transmitter
//   grant[NREQ]    one-hot owner of the current frame
//   done[NREQ]     one-cycle end-of-frame pulse to the owner
//   busy           scheduler is between ARB and the end of the inter-frame gap
interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] din_all;
  logic              cfg_we;
  logic [1:0]        cfg_idx;
  logic [3:0]        cfg_data;
  logic              tx_start_n;
  logic [7:0]        tx_din;
  logic [1:0]        tx_par;
  logic              tx_snum;
  logic              tx_dnum;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;

  modport master (
    output req, din_all, cfg_we, cfg_idx, cfg_data,
    input  tx_start_n, tx_din, tx_par, tx_snum, tx_dnum, grant, done, busy
  );

  modport slave (
    input  req, din_all, cfg_we, cfg_idx, cfg_data,
    output tx_start_n, tx_din, tx_par, tx_snum, tx_dnum, grant, done, busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one bit-per-clock UART transmitter among
// four requesters. The transmitter has no busy output, so frames are timed
// here by cycle count: 11 cycles with one stop bit, 12 with two.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : uart_tx_sched_if.slave (requests, config writes, transmitter
//          controls, grant/done/busy)
// Parameters:
//   NREQ : number of requesters (fixed at 4, index is 2 bits)
//   GAP  : idle cycles between consecutive frames (0..15)
module uart_tx_sched #(
  parameter int NREQ = 4,
  parameter int GAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [3:0] CFG_RST  = 4'b0110;  // par=01 (none), 1 stop, 8 bits
  localparam logic [3:0] GAP_CNT  = 4'(GAP);
  localparam logic [3:0] FLEN1_M1 = 4'd10;    // 11-cycle frame, one stop bit
  localparam logic [3:0] FLEN2_M1 = 4'd11;    // 12-cycle frame, two stop bits

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_owner;
  logic [3:0]        r_cnt;
  logic [3:0]        r_cfg [NREQ];

  logic              r_start_n;
  logic [7:0]        r_din;
  logic [1:0]        r_par;
  logic              r_snum;
  logic              r_dnum;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;

  logic [1:0]        w_win;
  logic [1:0]        w_idx;
  logic              w_any;

  // Round-robin pick: scan from the highest offset down so the request
  // closest to r_ptr is the last (winning) assignment.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_win = r_ptr;
    w_idx = '0;
    w_any = |bus.req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (bus.req[w_idx]) begin
        w_win = w_idx;
      end
    end
  end

  // Config registers are written in any state; ARB reads the pre-edge value,
  // so a same-cycle write to the winner's slot affects only its next frame.
  // NOTE: this small register file is reset explicitly because its reset value
  // defines the default frame format; large memories would not be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cfg[i] <= CFG_RST;
      end
    end else if (bus.cfg_we) begin
      r_cfg[bus.cfg_idx] <= bus.cfg_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_start_n <= 1'b1;
      r_din     <= '0;
      r_par     <= 2'b01;
      r_snum    <= 1'b1;
      r_dnum    <= 1'b0;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= '0;  // single-cycle pulse unless SEND raises it below
      case (r_state)
        S_IDLE: begin
          r_start_n <= 1'b1;
          if (w_any) begin
            r_state <= S_ARB;
            r_busy  <= 1'b1;
          end
        end

        S_ARB: begin
          if (w_any) begin
            r_din                    <= bus.din_all[8*w_win +: 8];
            {r_par, r_snum, r_dnum}  <= r_cfg[w_win];
            r_grant                  <= NREQ'(1) << w_win;
            r_owner                  <= w_win;
            r_ptr                    <= w_win + 2'd1;
            r_start_n                <= 1'b0;
            r_state                  <= S_START;
          end else begin
            // Request withdrawn before a winner was latched.
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_START: begin
          r_start_n <= 1'b1;
          // Frame length comes from the latched format, not the live config.
          r_cnt     <= r_snum ? FLEN1_M1 : FLEN2_M1;
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (r_cnt == 4'd1) begin
            r_done  <= NREQ'(1) << r_owner;
            r_grant <= '0;
            r_cnt   <= GAP_CNT;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_GAP: begin
          // The done cycle is the first GAP cycle; GAP more cycles follow.
          if (r_cnt == 4'd0) begin
            if (w_any) begin
              r_state <= S_ARB;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start_n = r_start_n;
  assign bus.tx_din     = r_din;
  assign bus.tx_par     = r_par;
  assign bus.tx_snum    = r_snum;
  assign bus.tx_dnum    = r_dnum;
  assign bus.grant      = r_grant;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched (NREQ=4, GAP=1).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_sched;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // {tx_start_n, tx_din, tx_par, tx_snum, tx_dnum, grant, done, busy}
  localparam logic [21:0] RST_VEC = {1'b1, 8'h00, 2'b01, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};

  uart_tx_sched_if #(.NREQ(4)) bus ();

  uart_tx_sched #(.NREQ(4), .GAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [21:0] out_vec();
    return {bus.tx_start_n, bus.tx_din, bus.tx_par, bus.tx_snum, bus.tx_dnum,
            bus.grant, bus.done, bus.busy};
  endfunction

  // Advance until the start strobe is seen low (bounded).
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.tx_start_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Advance until done is non-zero; lat counts cycles since the start-low cycle.
  task automatic wait_done(input int already, output int lat);
    lat = -1;
    for (int i = already + 1; i < 40; i++) begin
      tick();
      if (bus.done !== 4'b0000) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    bus.req     = '0;
    bus.din_all = '0;
    bus.cfg_we  = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_data = '0;
    tick();
    tick();
    n_vec++;
    if (out_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", out_vec(), RST_VEC);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    bit early;
    bus.din_all = 32'h00A5_0000;
    bus.req     = 4'b0100;
    tick();
    n_vec++;
    if ({bus.busy, bus.tx_start_n, bus.grant} !== {1'b1, 1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL single_arb: got busy/start_n/grant %b want 1_1_0000",
               {bus.busy, bus.tx_start_n, bus.grant});
    end
    tick();
    n_vec++;
    if ({bus.tx_start_n, bus.tx_din, bus.tx_par, bus.grant} !== {1'b0, 8'hA5, 2'b01, 4'b0100}) begin
      n_err++;
      $display("FAIL single_start: got %h want %h",
               {bus.tx_start_n, bus.tx_din, bus.tx_par, bus.grant},
               {1'b0, 8'hA5, 2'b01, 4'b0100});
    end
    early = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.done !== 4'b0000 || bus.tx_start_n !== 1'b1) early = 1'b1;
    end
    n_vec++;
    if (early) begin
      n_err++;
      $display("FAIL single_early_done: got early done/start activity want none");
    end
    tick();
    n_vec++;
    if ({bus.done, bus.grant} !== {4'b0100, 4'b0000}) begin
      n_err++;
      $display("FAIL single_done_at_11: got done/grant %b want 0100_0000", {bus.done, bus.grant});
    end
    bus.req = 4'b0000;
    tick();
    n_vec++;
    if ({bus.done, bus.busy} !== {4'b0000, 1'b1}) begin
      n_err++;
      $display("FAIL single_gap: got done/busy %b want 0000_1", {bus.done, bus.busy});
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got busy %b want 0", bus.busy);
    end
    ok = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [3:0] got_g [5];
    int         at    [5];
    int         nfound;
    bit         ok;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    pulse_reset();
    bus.din_all = 32'h4433_2211;
    bus.req     = 4'b1111;
    nfound = 0;
    for (int c = 1; c <= 120 && nfound < 5; c++) begin
      tick();
      if (bus.tx_start_n === 1'b0) begin
        got_g[nfound] = bus.grant;
        at[nfound]    = c;
        nfound++;
      end
    end
    n_vec++;
    if (nfound != 5) begin
      n_err++;
      $display("FAIL rr_starts: got %0d start strobes want 5", nfound);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (got_g[i] !== exp_g[i]) begin
          n_err++;
          $display("FAIL rr_grant%0d: got %b want %b", i, got_g[i], exp_g[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        n_vec++;
        if (at[i] - at[i-1] != 14) begin
          n_err++;
          $display("FAIL rr_spacing%0d: got %0d want 14", i, at[i] - at[i-1]);
        end
      end
    end
    bus.req = 4'b0000;
    wait_idle(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL rr_idle: got busy stuck want busy 0");
    end
  endtask

  task automatic test_stop_bits();
    bit ok;
    int lat;
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'd0;
    bus.cfg_data = 4'b1100;
    tick();
    bus.cfg_we  = 1'b0;
    bus.din_all = 32'h0000_003C;
    bus.req     = 4'b0001;
    wait_start(ok);
    n_vec++;
    if (!ok || {bus.tx_din, bus.tx_par, bus.tx_snum, bus.tx_dnum, bus.grant} !==
               {8'h3C, 2'b11, 1'b0, 1'b0, 4'b0001}) begin
      n_err++;
      $display("FAIL stop2_format: got ok=%0d %h want %h", ok,
               {bus.tx_din, bus.tx_par, bus.tx_snum, bus.tx_dnum, bus.grant},
               {8'h3C, 2'b11, 1'b0, 1'b0, 4'b0001});
    end
    wait_done(0, lat);
    n_vec++;
    if (lat != 12 || bus.done !== 4'b0001) begin
      n_err++;
      $display("FAIL stop2_latency: got %0d done %b want 12 done 0001", lat, bus.done);
    end
    bus.req = 4'b0000;
    wait_idle(ok);
  endtask

  task automatic test_cfg_midframe();
    bit ok;
    int lat;
    bus.din_all = 32'h0000_5A00;
    bus.req     = 4'b0010;
    wait_start(ok);
    n_vec++;
    if (!ok || {bus.grant, bus.tx_dnum} !== {4'b0010, 1'b0}) begin
      n_err++;
      $display("FAIL cfgmid_first: got ok=%0d grant/dnum %b want 0010_0", ok, {bus.grant, bus.tx_dnum});
    end
    tick(); tick(); tick();
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'd1;
    bus.cfg_data = 4'b0001;
    tick();
    bus.cfg_we = 1'b0;
    n_vec++;
    if ({bus.tx_par, bus.tx_snum, bus.tx_dnum} !== 4'b0110) begin
      n_err++;
      $display("FAIL cfgmid_hold: got %b want 0110", {bus.tx_par, bus.tx_snum, bus.tx_dnum});
    end
    wait_done(4, lat);
    n_vec++;
    if (lat != 11 || bus.done !== 4'b0010) begin
      n_err++;
      $display("FAIL cfgmid_done1: got %0d done %b want 11 done 0010", lat, bus.done);
    end
    bus.req = 4'b0000;
    wait_idle(ok);
    bus.req = 4'b0010;
    wait_start(ok);
    n_vec++;
    if (!ok || {bus.tx_par, bus.tx_snum, bus.tx_dnum} !== 4'b0001) begin
      n_err++;
      $display("FAIL cfgmid_next: got ok=%0d %b want 0001", ok, {bus.tx_par, bus.tx_snum, bus.tx_dnum});
    end
    wait_done(0, lat);
    n_vec++;
    if (lat != 12) begin
      n_err++;
      $display("FAIL cfgmid_done2: got %0d want 12", lat);
    end
    bus.req = 4'b0000;
    wait_idle(ok);
  endtask

  task automatic test_reset_midsend();
    bit ok;
    int lat;
    bus.din_all = 32'h0077_0000;
    bus.req     = 4'b0100;
    wait_start(ok);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %h want %h", out_vec(), RST_VEC);
    end
    tick();
    n_vec++;
    if ({bus.done, bus.busy} !== 5'b0) begin
      n_err++;
      $display("FAIL rstmid_nodone: got done/busy %b want 00000", {bus.done, bus.busy});
    end
    rst     = 1'b1;
    bus.req = 4'b1111;
    wait_start(ok);
    n_vec++;
    if (!ok || {bus.grant, bus.tx_par, bus.tx_snum} !== {4'b0001, 2'b01, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_ptr_cfg: got ok=%0d %b want 0001_01_1", ok,
               {bus.grant, bus.tx_par, bus.tx_snum});
    end
    wait_done(0, lat);
    n_vec++;
    if (lat != 11) begin
      n_err++;
      $display("FAIL rstmid_latency: got %0d want 11", lat);
    end
    bus.req = 4'b0000;
    wait_idle(ok);
  endtask

  task automatic test_req_drop();
    bit ok;
    int lat;
    bus.din_all = 32'hC300_0000;
    bus.req     = 4'b1000;
    wait_start(ok);
    tick();
    bus.req = 4'b0000;
    wait_done(1, lat);
    n_vec++;
    if (lat != 11 || {bus.done, bus.grant} !== {4'b1000, 4'b0000}) begin
      n_err++;
      $display("FAIL drop_done: got %0d done/grant %b want 11 1000_0000", lat, {bus.done, bus.grant});
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL drop_gap_busy: got %b want 1", bus.busy);
    end
    tick();
    n_vec++;
    if ({bus.busy, bus.tx_start_n} !== 2'b01) begin
      n_err++;
      $display("FAIL drop_idle: got busy/start_n %b want 01", {bus.busy, bus.tx_start_n});
    end
  endtask

  task automatic test_arb_abort();
    bit stray;
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    n_vec++;
    if ({bus.busy, bus.grant, bus.tx_start_n} !== {1'b0, 4'b0000, 1'b1}) begin
      n_err++;
      $display("FAIL arb_abort: got %b want 0_0000_1", {bus.busy, bus.grant, bus.tx_start_n});
    end
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.tx_start_n !== 1'b1 || bus.done !== 4'b0000) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_err++;
      $display("FAIL arb_abort_quiet: got stray start/done want none");
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stop_bits();
    test_cfg_midframe();
    test_reset_midsend();
    test_req_drop();
    test_arb_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
